// File: rtl/sevseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are {a,b,c,d,e,f,g}, active-low.
package sevseg_pkg;

  localparam int MAX_DIGITS = 8;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [0:0] {
    SHOW = 1'b0,
    DEAD = 1'b1
  } sevseg_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      4'hF:    seg = 7'b0111000;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevseg_hex_encoder.sv
// Combinational nibble to active-low seven-segment decoder.
module sevseg_hex_encoder
  import sevseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/sevseg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with per-frame snapshot and dead time.
// Optional leading-zero blanking: define SEVSEG_LEADING_ZERO_BLANK_EN.
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int DEAD_CYCLES = 1
) (
  input  logic                    clk_7seg,
  input  logic                    Rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blank_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              sev_out,
  output logic                    dp_out,
  output logic                    frame_done
);

  localparam logic [0:0] ST_SHOW   = 1'(SHOW);
  localparam logic [0:0] ST_DEAD   = 1'(DEAD);
  localparam logic [2:0] LAST_IDX  = 3'(NUM_DIGITS - 1);
  localparam logic [3:0] DEAD_LAST = (DEAD_CYCLES > 0) ? 4'(DEAD_CYCLES - 1) : 4'd0;
  localparam bit         HAS_DEAD  = (DEAD_CYCLES > 0);

  // r_state/r_idx/r_dead_cnt describe the slot that the next edge presents.
  logic [0:0]              r_state;
  logic [2:0]              r_idx;
  logic [3:0]              r_dead_cnt;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_sev;
  logic                    r_dp;
  logic                    r_frame_done;

  logic [4*NUM_DIGITS-1:0] w_shadow_next;
  logic [NUM_DIGITS-1:0]   w_shadow_dp_next;
  logic [31:0]             w_val32;
  logic [7:0]              w_dp8;
  logic [3:0]              w_nibble;
  logic [6:0]              w_seg;
  logic                    w_lz_blank;
  logic                    w_show_en;
  logic [2:0]              w_idx_inc;
  logic [0:0]              w_state_next;
  logic [2:0]              w_idx_next;
  logic [3:0]              w_dead_next;
  logic                    w_frame_end;
  logic [NUM_DIGITS-1:0]   w_an_next;

  // The frame-end edge reloads the snapshot and digit 0 decodes the fresh word.
  assign w_shadow_next    = r_frame_done ? value : r_shadow;
  assign w_shadow_dp_next = r_frame_done ? dp    : r_shadow_dp;
  assign w_val32          = 32'(w_shadow_next);
  assign w_dp8            = 8'(w_shadow_dp_next);
  assign w_nibble         = w_val32[{r_idx, 2'b00} +: 4];
  assign w_idx_inc        = (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;

  sevseg_hex_encoder u_hex_encoder (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  // Blank digit idx>0 when it and every higher digit are zero with no dp.
  always_comb begin
    w_lz_blank = (r_idx != 3'd0);
    for (int j = 0; j < MAX_DIGITS; j++) begin
      if ((3'(j) >= r_idx) && ((w_val32[4*j +: 4] != 4'd0) || w_dp8[j])) begin
        w_lz_blank = 1'b0;
      end else begin
        w_lz_blank = w_lz_blank;
      end
    end
  end
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_show_en = (r_state == ST_SHOW) && !blank_en && !w_lz_blank;

  // Slot sequencing: SHOW for one cycle, then optional DEAD run, then next digit.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_dead_next  = r_dead_cnt;
    w_frame_end  = 1'b0;
    case (r_state)
      ST_SHOW: begin
        if (HAS_DEAD) begin
          w_state_next = ST_DEAD;
          w_dead_next  = DEAD_LAST;
        end else begin
          w_idx_next  = w_idx_inc;
          w_frame_end = (r_idx == LAST_IDX);
        end
      end
      ST_DEAD: begin
        if (r_dead_cnt == 4'd0) begin
          w_state_next = ST_SHOW;
          w_idx_next   = w_idx_inc;
          w_frame_end  = (r_idx == LAST_IDX);
        end else begin
          w_dead_next = r_dead_cnt - 4'd1;
        end
      end
      default: begin
        w_state_next = ST_SHOW;
        w_idx_next   = 3'd0;
        w_dead_next  = 4'd0;
      end
    endcase
  end

  // One-hot-zero active-low anode pattern for the presented slot.
  always_comb begin
    w_an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_an_next[i] = ~(w_show_en && (r_idx == 3'(i)));
    end
  end

  // State, snapshot and registered display outputs.
  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      r_state      <= ST_SHOW;
      r_idx        <= 3'd0;
      r_dead_cnt   <= 4'd0;
      r_shadow     <= value;
      r_shadow_dp  <= dp;
      r_an         <= '1;
      r_sev        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_dead_cnt   <= w_dead_next;
      r_shadow     <= w_shadow_next;
      r_shadow_dp  <= w_shadow_dp_next;
      r_an         <= w_an_next;
      r_sev        <= w_show_en ? w_seg : SEG_OFF;
      r_dp         <= w_show_en ? ~w_dp8[r_idx] : 1'b1;
      r_frame_done <= w_frame_end;
    end
  end

  assign an         = r_an;
  assign sev_out    = r_sev;
  assign dp_out     = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Self-checking bench for sevseg_scan_driver: three parameterisations checked
// against a cycle-count based reference model.
module tb_sevseg_scan_driver;

  logic        clk_7seg = 1'b0;
  logic        Rst;
  logic [31:0] value;
  logic [7:0]  dp;
  logic        blank_en;

  logic [7:0] an_a, an_b;
  logic [2:0] an_c;
  logic [6:0] sev_a, sev_b, sev_c;
  logic       dp_a, dp_b, dp_c, fd_a, fd_b, fd_c;

  int n_tests = 0;
  int n_fail  = 0;

  int nd[3];
  int dc[3];
  int t_m[3];
  logic [31:0] snap_m[3];
  logic [7:0]  sdp_m[3];
  logic [7:0]  e_an[3];
  logic [6:0]  e_sev[3];
  logic        e_dp[3];
  logic        e_fd[3];
  logic [7:0]  o_an[3];
  logic [6:0]  o_sev[3];
  logic        o_dp[3];
  logic        o_fd[3];

  logic [7:0] an_seq [8];
  logic [6:0] seg_seq [8];

  always #5 clk_7seg = ~clk_7seg;

  sevseg_scan_driver #(.NUM_DIGITS(8), .DEAD_CYCLES(0)) u_dut_a (
    .clk_7seg(clk_7seg), .Rst(Rst), .value(value), .dp(dp), .blank_en(blank_en),
    .an(an_a), .sev_out(sev_a), .dp_out(dp_a), .frame_done(fd_a));

  sevseg_scan_driver #(.NUM_DIGITS(8), .DEAD_CYCLES(1)) u_dut_b (
    .clk_7seg(clk_7seg), .Rst(Rst), .value(value), .dp(dp), .blank_en(blank_en),
    .an(an_b), .sev_out(sev_b), .dp_out(dp_b), .frame_done(fd_b));

  sevseg_scan_driver #(.NUM_DIGITS(3), .DEAD_CYCLES(2)) u_dut_c (
    .clk_7seg(clk_7seg), .Rst(Rst), .value(value[11:0]), .dp(dp[2:0]), .blank_en(blank_en),
    .an(an_c), .sev_out(sev_c), .dp_out(dp_c), .frame_done(fd_c));

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001; 4'h1: s = 7'b1001111; 4'h2: s = 7'b0010010; 4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100; 4'h5: s = 7'b0100100; 4'h6: s = 7'b0100000; 4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000; 4'h9: s = 7'b0000100; 4'hA: s = 7'b0001000; 4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001; 4'hD: s = 7'b1000010; 4'hE: s = 7'b0110000; default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Reference: position in frame follows from cycles since reset.
  task automatic model_tick();
    for (int k = 0; k < 3; k++) begin
      int f, p, d;
      logic show, lz;
      logic [63:0] vmask;
      f = nd[k] * (1 + dc[k]);
      vmask = (64'd1 << (4 * nd[k])) - 64'd1;
      if (Rst) begin
        t_m[k] = -1;
        snap_m[k] = value & vmask[31:0];
        sdp_m[k] = dp & 8'((16'd1 << nd[k]) - 16'd1);
        e_an[k] = 8'hFF; e_sev[k] = 7'h7F; e_dp[k] = 1'b1; e_fd[k] = 1'b0;
      end else begin
        if (e_fd[k]) begin
          snap_m[k] = value & vmask[31:0];
          sdp_m[k] = dp & 8'((16'd1 << nd[k]) - 16'd1);
        end
        t_m[k] = (t_m[k] + 1) % f;
        p = t_m[k];
        d = p / (1 + dc[k]);
        show = ((p % (1 + dc[k])) == 0);
        e_fd[k] = (p == f - 1);
        lz = 1'b0;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        if (d > 0 && (snap_m[k] >> (4 * d)) == 32'd0 && (sdp_m[k] >> d) == 8'd0) lz = 1'b1;
`endif
        if (show && !blank_en && !lz) begin
          e_an[k] = ~(8'd1 << d);
          e_sev[k] = ref_seg(4'((snap_m[k] >> (4 * d)) & 32'hF));
          e_dp[k] = ~sdp_m[k][d];
        end else begin
          e_an[k] = 8'hFF; e_sev[k] = 7'h7F; e_dp[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_7seg);
    model_tick();
    @(negedge clk_7seg);
    o_an[0] = an_a;               o_an[1] = an_b;  o_an[2] = {5'b11111, an_c};
    o_sev[0] = sev_a;             o_sev[1] = sev_b; o_sev[2] = sev_c;
    o_dp[0] = dp_a;               o_dp[1] = dp_b;  o_dp[2] = dp_c;
    o_fd[0] = fd_a;               o_fd[1] = fd_b;  o_fd[2] = fd_c;
  endtask

  task automatic do_reset(input logic [31:0] v, input logic [7:0] d);
    Rst = 1'b1; value = v; dp = d; blank_en = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; value = 32'h12345678; dp = 8'h00; blank_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (an_a !== 8'hFF || sev_a !== 7'h7F || an_b !== 8'hFF || an_c !== 3'b111 || fd_a !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got an=%h sev=%b, want an=ff sev=1111111", c, an_a, sev_a);
      end
    end
    Rst = 1'b0;
    tick();
    n_tests++;
    if (an_a !== 8'hFE || sev_a !== 7'b0000000 || an_b !== 8'hFE || an_c !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_first: got an=%h sev=%b an_b=%h an_c=%b, want an=fe sev=0000000", an_a, sev_a, an_b, an_c);
    end
  endtask

  task automatic test_scan_d0();
    do_reset(32'h12345678, 8'h00);
    for (int c = 0; c < 16; c++) begin
      tick();
      n_tests++;
      if (an_a !== an_seq[c % 8] || sev_a !== seg_seq[c % 8] || fd_a !== ((c % 8) == 7)) begin
        n_fail++;
        $display("FAIL scan_d0 cyc%0d: got an=%h sev=%b fd=%b, want an=%h sev=%b fd=%b",
                 c, an_a, sev_a, fd_a, an_seq[c % 8], seg_seq[c % 8], ((c % 8) == 7));
      end
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (o_an[k] !== e_an[k] || o_sev[k] !== e_sev[k] || o_dp[k] !== e_dp[k] || o_fd[k] !== e_fd[k]) begin
          n_fail++;
          $display("FAIL scan_d0 dut%0d: got an=%h sev=%b dp=%b fd=%b, want an=%h sev=%b dp=%b fd=%b",
                   k, o_an[k], o_sev[k], o_dp[k], o_fd[k], e_an[k], e_sev[k], e_dp[k], e_fd[k]);
        end
      end
    end
  endtask

  task automatic test_dead1();
    int last;
    last = -1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (fd_b) begin
        if (last >= 0) begin
          n_tests++;
          if (c - last != 16) begin
            n_fail++;
            $display("FAIL dead1_period: got %0d cycles, want 16", c - last);
          end
        end
        last = c;
      end
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (o_an[k] !== e_an[k] || o_sev[k] !== e_sev[k] || o_dp[k] !== e_dp[k] || o_fd[k] !== e_fd[k]) begin
          n_fail++;
          $display("FAIL dead1 dut%0d: got an=%h sev=%b dp=%b fd=%b, want an=%h sev=%b dp=%b fd=%b",
                   k, o_an[k], o_sev[k], o_dp[k], o_fd[k], e_an[k], e_sev[k], e_dp[k], e_fd[k]);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    do_reset(32'h12345678, 8'h00);
    for (int c = 0; c < 24; c++) begin
      tick();
      if (c == 3) value = 32'hDEADBEEF;
      if (c >= 4 && c <= 8) begin
        n_tests++;
        if (sev_a !== ((c == 8) ? 7'b0111000 : seg_seq[c])) begin
          n_fail++;
          $display("FAIL snapshot cyc%0d: got sev=%b, want %b", c, sev_a, (c == 8) ? 7'b0111000 : seg_seq[c]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (o_an[k] !== e_an[k] || o_sev[k] !== e_sev[k] || o_dp[k] !== e_dp[k] || o_fd[k] !== e_fd[k]) begin
          n_fail++;
          $display("FAIL snapshot dut%0d: got an=%h sev=%b dp=%b fd=%b, want an=%h sev=%b dp=%b fd=%b",
                   k, o_an[k], o_sev[k], o_dp[k], o_fd[k], e_an[k], e_sev[k], e_dp[k], e_fd[k]);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [7:0] want_an;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(32'h000000A0, (pass == 0) ? 8'h00 : 8'h10);
      for (int c = 0; c < 24; c++) begin
        tick();
        if (c < 8) begin
          want_an = ~(8'd1 << c);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
          if (c > ((pass == 0) ? 1 : 4)) want_an = 8'hFF;
`endif
          n_tests++;
          if (an_a !== want_an) begin
            n_fail++;
            $display("FAIL lzb pass%0d cyc%0d: got an=%h, want %h", pass, c, an_a, want_an);
          end
        end
        for (int k = 0; k < 3; k++) begin
          n_tests++;
          if (o_an[k] !== e_an[k] || o_sev[k] !== e_sev[k] || o_dp[k] !== e_dp[k] || o_fd[k] !== e_fd[k]) begin
            n_fail++;
            $display("FAIL lzb dut%0d: got an=%h sev=%b dp=%b fd=%b, want an=%h sev=%b dp=%b fd=%b",
                     k, o_an[k], o_sev[k], o_dp[k], o_fd[k], e_an[k], e_sev[k], e_dp[k], e_fd[k]);
          end
        end
      end
    end
  endtask

  task automatic test_blank();
    do_reset($urandom, 8'($urandom));
    for (int c = 0; c < 40; c++) begin
      blank_en = (c >= 10 && c < 15);
      tick();
      if (c >= 10 && c < 15) begin
        n_tests++;
        if (an_a !== 8'hFF || an_b !== 8'hFF || sev_a !== 7'h7F) begin
          n_fail++;
          $display("FAIL blank cyc%0d: got an_a=%h an_b=%h sev=%b, want ff ff 1111111", c, an_a, an_b, sev_a);
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (o_an[k] !== e_an[k] || o_sev[k] !== e_sev[k] || o_dp[k] !== e_dp[k] || o_fd[k] !== e_fd[k]) begin
          n_fail++;
          $display("FAIL blank dut%0d: got an=%h sev=%b dp=%b fd=%b, want an=%h sev=%b dp=%b fd=%b",
                   k, o_an[k], o_sev[k], o_dp[k], o_fd[k], e_an[k], e_sev[k], e_dp[k], e_fd[k]);
        end
      end
    end
    blank_en = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) value = $urandom;
      if ($urandom_range(0, 5) == 0) dp = 8'($urandom);
      if ($urandom_range(0, 3) == 0) value = value & 32'h0000_0FF0;
      blank_en = ($urandom_range(0, 9) == 0);
      Rst = ($urandom_range(0, 59) == 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (o_an[k] !== e_an[k] || o_sev[k] !== e_sev[k] || o_dp[k] !== e_dp[k] || o_fd[k] !== e_fd[k]) begin
          n_fail++;
          $display("FAIL random cyc%0d dut%0d: got an=%h sev=%b dp=%b fd=%b, want an=%h sev=%b dp=%b fd=%b",
                   c, k, o_an[k], o_sev[k], o_dp[k], o_fd[k], e_an[k], e_sev[k], e_dp[k], e_fd[k]);
        end
      end
    end
    Rst = 1'b0;
    blank_en = 1'b0;
  endtask

  initial begin
    nd[0] = 8; dc[0] = 0;
    nd[1] = 8; dc[1] = 1;
    nd[2] = 3; dc[2] = 2;
    for (int k = 0; k < 3; k++) begin
      t_m[k] = -1; e_fd[k] = 1'b0; snap_m[k] = 32'd0; sdp_m[k] = 8'd0;
    end
    an_seq[0] = 8'hFE; an_seq[1] = 8'hFD; an_seq[2] = 8'hFB; an_seq[3] = 8'hF7;
    an_seq[4] = 8'hEF; an_seq[5] = 8'hDF; an_seq[6] = 8'hBF; an_seq[7] = 8'h7F;
    seg_seq[0] = 7'b0000000; seg_seq[1] = 7'b0001111; seg_seq[2] = 7'b0100000; seg_seq[3] = 7'b0100100;
    seg_seq[4] = 7'b1001100; seg_seq[5] = 7'b0000110; seg_seq[6] = 7'b0010010; seg_seq[7] = 7'b1001111;
    Rst = 1'b1; value = 32'd0; dp = 8'd0; blank_en = 1'b0;

    test_reset();
    test_scan_d0();
    test_dead1();
    test_snapshot();
    test_leading_zero();
    test_blank();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sevseg_scan_driver.md
# sevseg_scan_driver

Time-multiplexed seven-segment scan driver for the 8-digit board display. It consumes the 32-bit debug/display word selected at top level and produces the anode and segment drives. Each frame is snapshotted so the digits stay coherent, and a programmable dead time between digits suppresses ghosting. Leading-zero blanking can be compiled in. The block replaces the inline scan/decode logic in the SoC top and runs on the slow display clock.

## Interface
Parameters:
- NUM_DIGITS, 8, number of digits scanned (1..8); value width = 4*NUM_DIGITS
- DEAD_CYCLES, 1, all-anodes-off cycles after each digit (0..15)

Ports:
- clk_7seg  in  1  display scan clock
- Rst  in  1  reset, synchronous, active-high
- value  in  4*NUM_DIGITS  hex word to display, digit i = value[4i+3:4i]
- dp  in  NUM_DIGITS  decimal point request per digit
- blank_en  in  1  force display dark (scan keeps running)
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-zero
- sev_out  out  7  segments {a,b,c,d,e,f,g}, active-low
- dp_out  out  1  decimal point segment, active-low
- frame_done  out  1  one-cycle pulse, last cycle of each frame

## Operation
- Registers:
  - shadow value/dp (snapshot)
  - digit index idx (0..NUM_DIGITS-1)
  - state SHOW/DEAD
  - dead counter
- SHOW lasts 1 cycle at idx. If DEAD_CYCLES>0, the next state is DEAD for DEAD_CYCLES cycles; otherwise the block goes straight to SHOW at idx+1.
- idx wraps from NUM_DIGITS-1 to 0. The slot that ends at the wrap is the frame end, and frame_done is high during its final cycle.
- Snapshot: at the frame-end edge, shadow <= value and shadow_dp <= dp. Digit 0 of the new frame must display the newly loaded snapshot. Mid-frame changes on value/dp are ignored until then.
- SHOW outputs:
  - an = ~(1<<idx)
  - sev_out = hex encoding of the shadow nibble: 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100, A→0001000, b→1100000, C→0110001, d→1000010, E→0110000, F→0111000
  - dp_out = ~shadow_dp[idx]
- DEAD outputs: an all ones, sev_out=7'h7F, dp_out=1.
- blank_en high: outputs take DEAD values at the next edge. idx, state and snapshot continue to advance, and frame_done is unaffected.

## Timing
- Reset, while Rst is high: an all ones, sev_out=7'h7F, dp_out=1, frame_done=0, idx=0, state=SHOW, shadow<=value, shadow_dp<=dp.
- All outputs are registered. At the first edge with Rst low, digit 0 of the reset-time snapshot is driven.
- Slot = 1+DEAD_CYCLES cycles. Frame = NUM_DIGITS*(1+DEAD_CYCLES) cycles. frame_done period = frame length.
- Reset mid-frame: at the next edge, outputs go dark, idx returns to 0 and the snapshot reloads. There is no partial-frame pulse.
- DEAD_CYCLES=0: no DEAD state; consecutive anodes are driven on back-to-back cycles.

## Configuration
- SEVSEG_LEADING_ZERO_BLANK_EN defined: digit i>0 is blanked when shadow nibbles i..NUM_DIGITS-1 are all zero and shadow_dp[NUM_DIGITS-1:i]==0.
  - Blanked digits drive DEAD output values during their SHOW cycle; timing is unchanged.
  - Digit 0 is never blanked.
- Macro undefined: every digit is always shown, including leading zeros.

## Structure
- sevseg_pkg holds:
  - state enum {SHOW, DEAD}
  - SEG_OFF=7'h7F constant
  - hex-to-segment function/table
  - MAX_DIGITS=8
- One sub-module: sevseg_hex_encoder, a combinational nibble→7-bit active-low decoder, instantiated on the next-cycle nibble.

## Test plan
- Reset: value=32'h12345678, hold Rst 3 cycles → an=8'hFF and sev_out=7'h7F throughout. At the first post-reset edge, an=8'hFE and sev_out=7'b0000000 ("8").
- DEAD_CYCLES=0, value=32'h12345678 → an sequence FE,FD,FB,F7,EF,DF,BF,7F repeating with segments 8,7,6,5,4,3,2,1. frame_done pulses every 8 cycles, during the an=7F cycle.
- DEAD_CYCLES=1: each anode is active 1 cycle, followed by 1 cycle of an=FF/sev_out=7F. frame_done period is 16 cycles.
- Change value to 32'hDEADBEEF while idx=3 → the remaining digits of that frame still show 0x12345678's nibbles. The next frame starts with "F" on digit 0.
- With SEVSEG_LEADING_ZERO_BLANK_EN, value=32'h000000A0, dp=0 → digits 2..7 stay dark and digits 1/0 show "A"/"0". With dp=8'h10, digits 4..0 show.
- blank_en pulsed high for 5 cycles mid-frame → an=FF for those 5 cycles. The scan resumes at the idx it reached, and frame_done timing is unchanged.
